// File: rtl/bp_pkg.sv
// Shared types, counter encodings and the saturating-counter helper for the
// branch history predictor.
package bp_pkg;

   typedef logic [1:0] counter_t;

   localparam counter_t STRONG_NT = 2'b00;
   localparam counter_t WEAK_NT   = 2'b01;
   localparam counter_t WEAK_T    = 2'b10;
   localparam counter_t STRONG_T  = 2'b11;

   localparam int unsigned MODE_BIMODAL = 0;
   localparam int unsigned MODE_GSHARE  = 1;

   function automatic counter_t sat_update(counter_t ctr, logic taken);
      counter_t res;
      res = ctr;
      if (taken) begin
         if (ctr != STRONG_T) res = ctr + 2'b01;
      end else begin
         if (ctr != STRONG_NT) res = ctr - 2'b01;
      end
      return res;
   endfunction

endpackage

// File: rtl/pattern_history_table.sv
// Array of 2-bit saturating counters: one combinational read port and one
// read-modify-write training port.
module pattern_history_table
   import bp_pkg::*;
#(
   parameter int unsigned ENTRIES      = 64,
   parameter counter_t    COUNTER_INIT = WEAK_NT,
   localparam int unsigned IDX_W       = $clog2(ENTRIES)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [IDX_W-1:0] rd_index_i,
   output counter_t         rd_counter_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_index_i,
   input  logic             wr_taken_i
);

   counter_t table_q [ENTRIES];

   // Read returns the pre-update value on a same-cycle collision.
   assign rd_counter_o = table_q[rd_index_i];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            table_q[i] <= COUNTER_INIT;
         end
      end else if (wr_en_i) begin
         table_q[wr_index_i] <= sat_update(table_q[wr_index_i], wr_taken_i);
      end
   end

endmodule

// File: rtl/branch_history_predictor.sv
// Fetch-stage next-PC predictor: bimodal or gshare indexed counter table,
// trained from execute, with resolved-branch and mispredict statistics.
module branch_history_predictor
   import bp_pkg::*;
#(
   parameter int unsigned ENTRIES      = 64,
   parameter int unsigned HIST_BITS    = 6,
   parameter int unsigned MODE         = MODE_GSHARE,
   parameter counter_t    COUNTER_INIT = WEAK_NT,
   localparam int unsigned IDX_W       = $clog2(ENTRIES)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [31:0]      pc_i,
   input  logic [31:0]      pc_plus_4_i,
   input  logic [31:0]      target_i,
   input  logic             is_branch_i,
   input  logic             is_jump_i,
   output logic [31:0]      pc_next_o,
   output logic             taken_o,
   output logic [IDX_W-1:0] index_o,
   input  logic             update_en_i,
   input  logic [IDX_W-1:0] update_index_i,
   input  logic             update_taken_i,
   input  logic             update_mispredict_i,
   output logic [31:0]      branch_cnt_o,
   output logic [31:0]      mispredict_cnt_o
);

   logic [HIST_BITS-1:0] ghr_q, ghr_d;
   logic [31:0]          branch_cnt_q, mispredict_cnt_q;
   logic [IDX_W-1:0]     pc_idx, ghr_ext, idx;
   counter_t             rd_counter;

   assign pc_idx  = pc_i[IDX_W+1:2];
   assign ghr_ext = IDX_W'(ghr_q);

   generate
      if (MODE == MODE_GSHARE) begin : g_gshare
         assign idx = pc_idx ^ ghr_ext;
      end else begin : g_bimodal
         assign idx = pc_idx;
      end

      if (HIST_BITS == 1) begin : g_hist1
         assign ghr_d = update_taken_i;
      end else begin : g_histn
         assign ghr_d = {ghr_q[HIST_BITS-2:0], update_taken_i};
      end
   endgenerate

   pattern_history_table #(
      .ENTRIES      (ENTRIES),
      .COUNTER_INIT (COUNTER_INIT)
   ) u_pht (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .rd_index_i   (idx),
      .rd_counter_o (rd_counter),
      .wr_en_i      (update_en_i),
      .wr_index_i   (update_index_i),
      .wr_taken_i   (update_taken_i)
   );

   always_comb begin
      taken_o   = 1'b0;
      pc_next_o = pc_plus_4_i;
      if (is_jump_i) begin
         taken_o   = 1'b1;
         pc_next_o = target_i;
      end else if (is_branch_i) begin
         taken_o   = rd_counter[1];
         pc_next_o = rd_counter[1] ? target_i : pc_plus_4_i;
      end
   end

   assign index_o = idx;

   // History is non-speculative: it only moves on a resolved branch.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ghr_q            <= '0;
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else if (update_en_i) begin
         ghr_q            <= ghr_d;
         branch_cnt_q     <= branch_cnt_q + 32'd1;
         mispredict_cnt_q <= mispredict_cnt_q + {31'b0, update_mispredict_i};
      end
   end

   assign branch_cnt_o     = branch_cnt_q;
   assign mispredict_cnt_o = mispredict_cnt_q;

   // Bits that do not feed the index or the direction decision in every mode.
   logic unused_bits;
   assign unused_bits = ^{pc_i[31:IDX_W+2], pc_i[1:0], rd_counter[0], ghr_q};

endmodule

// File: tb/tb_branch_history_predictor.sv
// Directed table-driven bench: a gshare and a bimodal instance share stimulus
// and are compared against hand-computed expectations.
module tb_branch_history_predictor;

   localparam int unsigned ENTRIES = 16;
   localparam int unsigned IDX_W   = 4;

   localparam logic [31:0] PC_L = 32'h0040_0010;
   localparam logic [31:0] P4_L = 32'h0040_0014;
   localparam logic [31:0] TG_L = 32'h0040_0040;
   localparam logic [31:0] TG_J = 32'h0040_0100;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      pc, pc4, tgt;
   logic             is_branch, is_jump;
   logic             upd_en, upd_taken, upd_mis;
   logic [IDX_W-1:0] upd_idx;

   logic [31:0]      g_next, b_next, g_bcnt, b_bcnt, g_mcnt, b_mcnt;
   logic             g_taken, b_taken;
   logic [IDX_W-1:0] g_idx, b_idx;

   always #5 clk = ~clk;

   branch_history_predictor #(
      .ENTRIES(ENTRIES), .HIST_BITS(4), .MODE(1), .COUNTER_INIT(2'b01)
   ) dut_g (
      .clk_i(clk), .rst_i(rst), .pc_i(pc), .pc_plus_4_i(pc4), .target_i(tgt),
      .is_branch_i(is_branch), .is_jump_i(is_jump), .pc_next_o(g_next),
      .taken_o(g_taken), .index_o(g_idx), .update_en_i(upd_en),
      .update_index_i(upd_idx), .update_taken_i(upd_taken),
      .update_mispredict_i(upd_mis), .branch_cnt_o(g_bcnt), .mispredict_cnt_o(g_mcnt)
   );

   branch_history_predictor #(
      .ENTRIES(ENTRIES), .HIST_BITS(4), .MODE(0), .COUNTER_INIT(2'b01)
   ) dut_b (
      .clk_i(clk), .rst_i(rst), .pc_i(pc), .pc_plus_4_i(pc4), .target_i(tgt),
      .is_branch_i(is_branch), .is_jump_i(is_jump), .pc_next_o(b_next),
      .taken_o(b_taken), .index_o(b_idx), .update_en_i(upd_en),
      .update_index_i(upd_idx), .update_taken_i(upd_taken),
      .update_mispredict_i(upd_mis), .branch_cnt_o(b_bcnt), .mispredict_cnt_o(b_mcnt)
   );

   typedef struct {
      logic        rst, ue;
      logic [3:0]  ui;
      logic        ut, um;
      logic [31:0] pc, p4, tg;
      logic        br, jp;
      logic [3:0]  gi;
      logic        gt;
      logic [31:0] gn;
      logic [3:0]  bi;
      logic        bt;
      logic [31:0] bn;
      logic [31:0] bc, mc;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int step, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
      end
   endtask

   function automatic vec_t mk(
      logic r, logic ue, logic [3:0] ui, logic ut, logic um,
      logic [31:0] p, logic [31:0] p4, logic [31:0] tg, logic br, logic jp,
      logic [3:0] gi, logic gt, logic [31:0] gn,
      logic [3:0] bi, logic bt, logic [31:0] bn, logic [31:0] bc, logic [31:0] mc);
      vec_t v;
      v.rst = r; v.ue = ue; v.ui = ui; v.ut = ut; v.um = um;
      v.pc = p; v.p4 = p4; v.tg = tg; v.br = br; v.jp = jp;
      v.gi = gi; v.gt = gt; v.gn = gn; v.bi = bi; v.bt = bt; v.bn = bn;
      v.bc = bc; v.mc = mc;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rst = v.rst; upd_en = v.ue; upd_idx = v.ui; upd_taken = v.ut; upd_mis = v.um;
      pc = v.pc; pc4 = v.p4; tgt = v.tg; is_branch = v.br; is_jump = v.jp;
   endtask

   vec_t vecs [23];

   initial begin
      // Checks observe state before the edge; the update applies at that edge.
      vecs[0]  = mk(1,1,4,1,1, PC_L,P4_L,TG_L,1,0,  4,0,P4_L,  4,0,P4_L, 0,0);
      vecs[1]  = mk(0,0,0,0,0, PC_L,P4_L,TG_L,1,0,  4,0,P4_L,  4,0,P4_L, 0,0);
      vecs[2]  = mk(0,1,4,1,1, PC_L,P4_L,TG_L,1,0,  4,0,P4_L,  4,0,P4_L, 0,0);
      vecs[3]  = mk(0,0,0,0,0, PC_L,P4_L,TG_L,1,0,  5,0,P4_L,  4,1,TG_L, 1,1);
      vecs[4]  = mk(0,1,4,1,0, PC_L,P4_L,TG_L,1,0,  5,0,P4_L,  4,1,TG_L, 1,1);
      vecs[5]  = mk(0,1,4,1,0, PC_L,P4_L,TG_L,1,0,  7,0,P4_L,  4,1,TG_L, 2,1);
      vecs[6]  = mk(0,1,4,0,1, PC_L,P4_L,TG_L,1,0,  3,0,P4_L,  4,1,TG_L, 3,1);
      vecs[7]  = mk(0,1,4,0,0, PC_L,P4_L,TG_L,1,0, 10,0,P4_L,  4,1,TG_L, 4,2);
      vecs[8]  = mk(0,0,0,0,0, PC_L,P4_L,TG_L,1,0,  8,0,P4_L,  4,0,P4_L, 5,2);
      vecs[9]  = mk(0,1,2,0,0, PC_L,P4_L,TG_L,1,0,  8,0,P4_L,  4,0,P4_L, 5,2);
      vecs[10] = mk(0,1,2,0,0, PC_L,P4_L,TG_L,1,0, 12,0,P4_L,  4,0,P4_L, 6,2);
      vecs[11] = mk(0,0,0,0,0, 32'h0040_0008,32'h0040_000C,32'h0040_0080,1,0,
                    2,0,32'h0040_000C, 2,0,32'h0040_000C, 7,2);
      vecs[12] = mk(0,0,0,0,0, PC_L,P4_L,TG_J,0,1,  4,1,TG_J,  4,1,TG_J, 7,2);
      vecs[13] = mk(0,0,0,0,0, PC_L,P4_L,TG_J,1,1,  4,1,TG_J,  4,1,TG_J, 7,2);
      vecs[14] = mk(0,0,0,0,0, PC_L,P4_L,TG_J,0,0,  4,0,P4_L,  4,0,P4_L, 7,2);
      vecs[15] = mk(0,0,0,0,0, PC_L,P4_L,TG_L,1,0,  4,0,P4_L,  4,0,P4_L, 7,2);
      vecs[16] = mk(0,1,0,1,0, PC_L,P4_L,TG_L,1,0,  4,0,P4_L,  4,0,P4_L, 7,2);
      vecs[17] = mk(0,1,0,0,0, PC_L,P4_L,TG_L,1,0,  5,0,P4_L,  4,0,P4_L, 8,2);
      vecs[18] = mk(0,1,0,1,0, PC_L,P4_L,TG_L,1,0,  6,0,P4_L,  4,0,P4_L, 9,2);
      vecs[19] = mk(0,1,0,1,0, PC_L,P4_L,TG_L,1,0,  1,0,P4_L,  4,0,P4_L, 10,2);
      vecs[20] = mk(0,0,0,0,0, PC_L,P4_L,TG_L,1,0, 15,0,P4_L,  4,0,P4_L, 11,2);
      vecs[21] = mk(0,0,0,0,0, 32'h0040_0000,32'h0040_0004,32'h0040_0200,1,0,
                    11,0,32'h0040_0004, 0,1,32'h0040_0200, 11,2);
      // Reset mid-run: table, history and statistics all return to reset state.
      vecs[22] = mk(1,1,0,0,1, 32'h0040_0000,32'h0040_0004,32'h0040_0200,1,0,
                    11,0,32'h0040_0004, 0,1,32'h0040_0200, 11,2);

      drive(vecs[1]);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);

      for (int i = 0; i < 23; i++) begin
         drive(vecs[i]);
         #1;
         check("g_index",   i, 32'(g_idx),   32'(vecs[i].gi));
         check("g_taken",   i, 32'(g_taken), 32'(vecs[i].gt));
         check("g_pc_next", i, g_next,       vecs[i].gn);
         check("b_index",   i, 32'(b_idx),   32'(vecs[i].bi));
         check("b_taken",   i, 32'(b_taken), 32'(vecs[i].bt));
         check("b_pc_next", i, b_next,       vecs[i].bn);
         check("g_branch_cnt", i, g_bcnt, vecs[i].bc);
         check("g_mispred_cnt", i, g_mcnt, vecs[i].mc);
         check("b_branch_cnt", i, b_bcnt, vecs[i].bc);
         check("b_mispred_cnt", i, b_mcnt, vecs[i].mc);
         @(posedge clk);
         @(negedge clk);
      end

      // After the mid-run reset: idx 0 back to weakly not-taken, ghr cleared.
      rst = 1'b0; upd_en = 1'b0;
      #1;
      check("post_rst_g_index", 100, 32'(g_idx), 32'd0);
      check("post_rst_b_taken", 100, 32'(b_taken), 32'd0);
      check("post_rst_b_next", 100, b_next, 32'h0040_0004);
      check("post_rst_bcnt", 100, g_bcnt, 32'd0);
      check("post_rst_mcnt", 100, b_mcnt, 32'd0);

      // Three mispredicted updates in a row accumulate in both statistics.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         upd_en = 1'b1; upd_idx = 4'd9; upd_taken = 1'b0; upd_mis = 1'b1;
      end
      @(negedge clk);
      upd_en = 1'b0;
      #1;
      check("burst_bcnt", 101, g_bcnt, 32'd3);
      check("burst_mcnt", 101, g_mcnt, 32'd3);
      // History now 0000; gshare index for pc 0 stays 0.
      check("burst_g_index", 101, 32'(g_idx), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_history_predictor.md
Name: branch_history_predictor

Overview:
- Dynamic direction predictor in the fetch stage, successor to the static fetch-stage decoder.
- Takes the decoded branch/jump flags and targets for the fetched instruction and predicts the next PC.
- Uses a table of 2-bit saturating counters indexed in bimodal or gshare mode.
- Trained from the execute stage through a resolution/update port, with mispredict statistics.

Parameters:
- ENTRIES, 64, number of pattern-table counters; power of 2, >= 4; IDX_W = log2(ENTRIES).
- HIST_BITS, 6, global history register width; 1 <= HIST_BITS <= IDX_W.
- MODE, 1, 0 = bimodal (PC-indexed), 1 = gshare (PC xor history).
- COUNTER_INIT, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- pc_i  in  32  PC of fetched instruction
- pc_plus_4_i  in  32  pc_i + 4 from decoder
- target_i  in  32  decoded branch/jump target
- is_branch_i  in  1  instruction is BEQ/BNE
- is_jump_i  in  1  instruction is J/JAL
- pc_next_o  out  32  predicted next PC
- taken_o  out  1  prediction is taken
- index_o  out  IDX_W  table index used; pipelined alongside the instruction
- update_en_i  in  1  a conditional branch resolved this cycle
- update_index_i  in  IDX_W  index_o carried from prediction time
- update_taken_i  in  1  actual branch outcome
- update_mispredict_i  in  1  resolved direction differed from prediction
- branch_cnt_o  out  32  resolved branches since reset
- mispredict_cnt_o  out  32  mispredictions since reset

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset state: all counters = COUNTER_INIT, ghr = 0, both statistic counters = 0. An update arriving in a reset cycle is discarded.
- Lookup is combinational, with zero latency from pc_i and flags to outputs.
- Index, bimodal: idx = pc_i[IDX_W+1:2].
- Index, gshare: idx = pc_i[IDX_W+1:2] xor zero-extended ghr.
- index_o = idx always, including for non-branches.
- If is_jump_i: taken_o = 1, pc_next_o = target_i; no table access.
- Else if is_branch_i: taken_o = table[idx][1]; pc_next_o = taken_o ? target_i : pc_plus_4_i.
- Otherwise: taken_o = 0, pc_next_o = pc_plus_4_i.
- If is_jump_i and is_branch_i are both high, the jump wins.
- Outputs are combinational from inputs and state; there is no output reset value beyond this.
- Update, on the rising edge when update_en_i and not rst_i:
  - table[update_index_i] saturating: +1 if taken (capped at 2'b11), -1 if not (floored at 2'b00).
  - ghr <= {ghr[HIST_BITS-2:0], update_taken_i}; for HIST_BITS = 1, ghr <= update_taken_i.
  - branch_cnt_o += 1.
  - mispredict_cnt_o += update_mispredict_i.
- In MODE 0, ghr is still maintained but unused.
- Read/write collision (update and lookup on the same index in the same cycle): lookup sees the pre-update counter; the new value is visible the next cycle. The same applies to ghr.
- Statistic counters wrap modulo 2^32; no saturation.
- No stall input: the caller holds pc_i stable, and prediction has no side effects.
- Mispredict recovery (redirect, flush) is outside this block. The history is non-speculative and changes only on update.

Decomposition:
- Package bp_pkg holds:
  - typedef counter_t (logic [1:0]).
  - Constants STRONG_NT = 2'b00, WEAK_NT = 2'b01, WEAK_T = 2'b10, STRONG_T = 2'b11.
  - Mode constants MODE_BIMODAL = 0, MODE_GSHARE = 1.
  - Function sat_update(counter_t, taken) returning counter_t.
- One sub-module is natural: pattern_history_table (ENTRIES x counter_t register array, one combinational read port, one synchronous write port, synchronous reset to COUNTER_INIT).

Test Plan:
All scenarios use ENTRIES = 16, HIST_BITS = 4, MODE = 1 unless noted.
- Post-reset branch lookup:
  - Stimulus: pc_i = 0x00400010, pc_plus_4_i = 0x00400014, target_i = 0x00400040, is_branch_i = 1.
  - Response: index_o = 4, taken_o = 0, pc_next_o = 0x00400014; both counts = 0.
- Saturation (MODE = 0):
  - Stimulus: three taken updates to index 4, then one not-taken; same lookup as above.
  - Response: counter goes 01 -> 10 -> 11 -> 11 -> 10. taken_o = 1 and pc_next_o = 0x00400040 from the first update onward. branch_cnt_o = 4.
- Jump:
  - Stimulus: is_jump_i = 1, target_i = 0x00400100.
  - Response: taken_o = 1, pc_next_o = 0x00400100; table unchanged. Non-branch with both flags 0 gives pc_next_o = pc_plus_4_i.
- Gshare history:
  - Stimulus: updates with outcomes 1, 0, 1, 1 to index 0, then lookup pc_i = 0x00400010.
  - Response: ghr = 4'b1011, index_o = 4 xor 11 = 15.
- Collision:
  - Stimulus: same cycle, update index 4 taken (01 -> 10) and branch lookup whose index_o = 4.
  - Response: taken_o = 0 that cycle, 1 the next cycle (ghr effect accounted for).
- Reset priority and stats:
  - Stimulus: update_en_i = 1, update_mispredict_i = 1 in the same cycle as rst_i = 1.
  - Response: counters remain 01, ghr = 0, branch_cnt_o = 0, mispredict_cnt_o = 0. Next cycle, a mispredicted update gives 1/1.
